mem_load_unit: RTL and testbench
================================

Name: mem_load_unit

Overview:
- Parametrised, handshaked successor to the combinational load-data path.
- Accepts one load request per transaction: address plus funct3.
- Decodes the target region (DMEM, BIOS, IO), pulses the selected read enable and waits a per-region latency.
- Then captures, byte-aligns and sign/zero-extends the read data into a registered response held under valid/ready backpressure.
- Sits between the memory stage and the DMEM/BIOS/IO read ports.

Parameters:
- XLEN, 32, data/address width; must be 32.
- MEM_LATENCY, 1, cycles from DMEM/BIOS enable to valid read data; legal range 1..7.
- IO_LATENCY, 1, cycles from io_rd_en to valid io_rdata; legal range 1..7.
- IO_ADDR_W, 8, width of the IO offset driven on io_addr.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  load request valid
- req_ready  out  1  unit can accept a request
- req_addr  in  XLEN  byte address
- req_funct3  in  3  load type: LB, LH, LW, LBU, LHU
- mem_addr  out  XLEN  address to DMEM/BIOS; equals req_addr during accept
- dmem_en  out  1  one-cycle DMEM read strobe
- bios_en  out  1  one-cycle BIOS read strobe
- io_rd_en  out  1  one-cycle IO read strobe
- io_addr  out  IO_ADDR_W  req_addr[IO_ADDR_W-1:0]
- dmem_rdata  in  XLEN  DMEM read data
- bios_rdata  in  XLEN  BIOS read data
- io_rdata  in  XLEN  IO read data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  XLEN  aligned, extended load data
- rsp_fault  out  1  unmapped region or illegal funct3 (or misalignment, see Optional Feature)

Behaviour:
- Reset (synchronous, rst high at posedge):
  - state=IDLE, counter=0.
  - rsp_valid=0, rsp_data=0, rsp_fault=0.
  - All strobes 0.
  - Reset mid-transaction aborts it; the pending response is dropped; no further strobes are issued.
- Region decode on req_addr[31:28]:
  - 4'b00?1 -> DMEM.
  - 4'b0100 -> BIOS.
  - 4'b1000 -> IO.
  - Anything else -> unmapped.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Accept = req_valid && req_ready in cycle T.
  - In cycle T, the strobe for the decoded region is driven combinationally for exactly one cycle. The unit latches addr[1:0], funct3 and region.
  - Mapped region with legal funct3: counter loads MEM_LATENCY or IO_LATENCY; next state WAIT.
  - Unmapped region or illegal funct3: no strobe; next state RESP with rsp_fault=1 and rsp_data=0 (rsp_valid in T+1).
- WAIT:
  - req_ready=0; counter decrements each cycle.
  - At the edge where counter==1, the selected source's rdata is sampled, formatted and registered into rsp_data (rsp_fault=0); next state RESP.
  - rsp_valid rises in cycle T+1+latency.
- RESP:
  - rsp_valid=1; rsp_data and rsp_fault are held stable.
  - On rsp_valid && rsp_ready -> IDLE, with rsp_valid deasserted next cycle.
  - req_ready=0, so back-to-back throughput is one load per latency+2 cycles.
- Formatting (byte offset o = addr[1:0]):
  - LB/LBU select byte o; sign- or zero-extend.
  - LH/LHU select halfword at o=0,1,2 (bits [15:0], [23:8], [31:16]); o=3 selects [15:0].
  - LW returns the full word, ignoring o.
- Simultaneous events: req_valid is ignored outside IDLE. rst has priority over any handshake.

Optional Feature:
- Macro: MEM_LOAD_MISALIGN_TRAP_EN.
- Defined:
  - LH/LHU with o=3, and LW with o!=0, are faults.
  - No strobe is issued; the unit goes straight to RESP with rsp_fault=1 and rsp_data=0.
- Undefined: misaligned loads use the formatting rules above with rsp_fault=0.

Decomposition:
- Shared header holds:
  - funct3 codes (FNC_LB..FNC_LHU).
  - Region codes (REG_DMEM, REG_BIOS, REG_IO, REG_NONE).
  - FSM state encodings.
- Sub-module load_align (purely combinational): inputs raw word, offset, funct3; output formatted word.

Test Plan:
- LW 0x10000004, dmem_rdata=0xDEADBEEF, MEM_LATENCY=1, accept at T -> dmem_en=1 only in T; rsp_data=0xDEADBEEF, rsp_fault=0, rsp_valid in T+2.
- LB 0x40000003, bios_rdata=0x80123456 -> rsp_data=0xFFFFFF80; LBU at the same address -> 0x00000080.
- LHU 0x80000012, IO_LATENCY=3, io_rdata=0xBEEF0000 -> io_rd_en in T, io_addr=0x12; rsp_data=0x0000BEEF with rsp_valid in T+4.
- LW 0x20000000 (unmapped) -> no strobes; rsp_fault=1, rsp_data=0, rsp_valid in T+1.
- rsp_ready held low 3 cycles in RESP -> rsp_valid/rsp_data stable and req_ready=0 throughout; IDLE one cycle after rsp_ready rises. Separately, rst pulsed during WAIT -> rsp_valid stays 0 and state=IDLE.
- LH 0x10000003, dmem_rdata=0x0000F00D -> without macro, rsp_data=0xFFFFF00D, fault=0; with MEM_LOAD_MISALIGN_TRAP_EN, no dmem_en and rsp_fault=1, rsp_data=0.

Source files
------------

// File: rtl/mem_load_unit_pkg.sv
// ============================================================================
//  Module   : mem_load_unit_pkg
//  Purpose  : Shared constants for the load unit: funct3 load codes, memory
//             region codes, FSM state encodings and decode helpers.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_load_unit_pkg;

   // RISC-V load funct3 encodings
   localparam logic [2:0] FNC_LB  = 3'b000;
   localparam logic [2:0] FNC_LH  = 3'b001;
   localparam logic [2:0] FNC_LW  = 3'b010;
   localparam logic [2:0] FNC_LBU = 3'b100;
   localparam logic [2:0] FNC_LHU = 3'b101;

   // Target region codes
   localparam logic [1:0] REG_NONE = 2'd0;
   localparam logic [1:0] REG_DMEM = 2'd1;
   localparam logic [1:0] REG_BIOS = 2'd2;
   localparam logic [1:0] REG_IO   = 2'd3;

   // FSM state encodings
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   // Region decode from address bits [31:28]
   function automatic logic [1:0] decode_region(input logic [3:0] i_nib);
      logic [1:0] w_reg;
      casez (i_nib)
         4'b00?1: w_reg = REG_DMEM;
         4'b0100: w_reg = REG_BIOS;
         4'b1000: w_reg = REG_IO;
         default: w_reg = REG_NONE;
      endcase
      return w_reg;
   endfunction

   function automatic logic funct3_legal(input logic [2:0] i_f3);
      return (i_f3 == FNC_LB)  || (i_f3 == FNC_LH) || (i_f3 == FNC_LW) ||
             (i_f3 == FNC_LBU) || (i_f3 == FNC_LHU);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_load_unit_align.sv
// ============================================================================
//  Module   : load_align
//  Purpose  : Combinational byte/halfword selection and sign/zero extension
//             of a raw read word.
//  Ports    : i_word   raw XLEN-bit read data
//             i_offset byte offset addr[1:0]
//             i_funct3 load type
//             o_data   aligned, extended result (0 for illegal funct3)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module load_align
   import mem_load_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] i_word,
   input  logic [1:0]      i_offset,
   input  logic [2:0]      i_funct3,
   output logic [XLEN-1:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_word[7:0];
      case (i_offset)
         2'd0:    w_byte = i_word[7:0];
         2'd1:    w_byte = i_word[15:8];
         2'd2:    w_byte = i_word[23:16];
         default: w_byte = i_word[31:24];
      endcase
   end

   // Offset 3 has no contiguous halfword inside the word; it falls back to
   // the low halfword.
   always_comb begin
      w_half = i_word[15:0];
      case (i_offset)
         2'd1:    w_half = i_word[23:8];
         2'd2:    w_half = i_word[31:16];
         default: w_half = i_word[15:0];
      endcase
   end

   always_comb begin
      o_data = '0;
      case (i_funct3)
         FNC_LB:  o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
         FNC_LBU: o_data = {{(XLEN-8){1'b0}}, w_byte};
         FNC_LH:  o_data = {{(XLEN-16){w_half[15]}}, w_half};
         FNC_LHU: o_data = {{(XLEN-16){1'b0}}, w_half};
         FNC_LW:  o_data = i_word;
         default: o_data = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mem_load_unit.sv
// ============================================================================
//  Module   : mem_load_unit
//  Purpose  : Handshaked load unit. Accepts one load (address + funct3),
//             strobes the decoded DMEM/BIOS/IO read port, waits the region
//             latency, then registers the aligned/extended data as a
//             response held under valid/ready backpressure.
//  Ports    : clk, rst (sync, active high)
//             req_valid/req_ready/req_addr/req_funct3   request side
//             mem_addr, dmem_en, bios_en, io_rd_en, io_addr   read ports
//             dmem_rdata, bios_rdata, io_rdata          read data
//             rsp_valid/rsp_ready/rsp_data/rsp_fault    response side
//  Macro    : MEM_LOAD_MISALIGN_TRAP_EN - misaligned LH/LHU/LW fault
//             instead of being formatted.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_load_unit
   import mem_load_unit_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int MEM_LATENCY = 1,
   parameter int IO_LATENCY  = 1,
   parameter int IO_ADDR_W   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [XLEN-1:0]      req_addr,
   input  logic [2:0]           req_funct3,
   output logic [XLEN-1:0]      mem_addr,
   output logic                 dmem_en,
   output logic                 bios_en,
   output logic                 io_rd_en,
   output logic [IO_ADDR_W-1:0] io_addr,
   input  logic [XLEN-1:0]      dmem_rdata,
   input  logic [XLEN-1:0]      bios_rdata,
   input  logic [XLEN-1:0]      io_rdata,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [XLEN-1:0]      rsp_data,
   output logic                 rsp_fault
);

   localparam logic [2:0] c_MEM_LAT = 3'(MEM_LATENCY);
   localparam logic [2:0] c_IO_LAT  = 3'(IO_LATENCY);

   logic [1:0]      r_state;
   logic [2:0]      r_cnt;
   logic [1:0]      r_off;
   logic [2:0]      r_funct3;
   logic [1:0]      r_region;
   logic [XLEN-1:0] r_rsp_data;
   logic            r_rsp_fault;

   logic [1:0]      w_region;
   logic            w_misalign;
   logic            w_fault;
   logic            w_accept;
   logic            w_strobe;
   logic [XLEN-1:0] w_rdata;
   logic [XLEN-1:0] w_aligned;

   assign w_region = decode_region(req_addr[31:28]);

`ifdef MEM_LOAD_MISALIGN_TRAP_EN
   assign w_misalign = (((req_funct3 == FNC_LH) || (req_funct3 == FNC_LHU)) &&
                        (req_addr[1:0] == 2'd3)) ||
                       ((req_funct3 == FNC_LW) && (req_addr[1:0] != 2'd0));
`else
   assign w_misalign = 1'b0;
`endif

   assign w_fault  = (w_region == REG_NONE) || !funct3_legal(req_funct3) || w_misalign;
   assign w_accept = req_valid && (r_state == ST_IDLE);
   // A faulting request never touches a read port
   assign w_strobe = w_accept && !w_fault;

   assign req_ready = (r_state == ST_IDLE);
   assign mem_addr  = req_addr;
   assign io_addr   = req_addr[IO_ADDR_W-1:0];
   assign dmem_en   = w_strobe && (w_region == REG_DMEM);
   assign bios_en   = w_strobe && (w_region == REG_BIOS);
   assign io_rd_en  = w_strobe && (w_region == REG_IO);

   assign rsp_valid = (r_state == ST_RESP);
   assign rsp_data  = r_rsp_data;
   assign rsp_fault = r_rsp_fault;

   always_comb begin
      w_rdata = dmem_rdata;
      case (r_region)
         REG_BIOS: w_rdata = bios_rdata;
         REG_IO:   w_rdata = io_rdata;
         default:  w_rdata = dmem_rdata;
      endcase
   end

   load_align #(.XLEN(XLEN)) u_align (
      .i_word   (w_rdata),
      .i_offset (r_off),
      .i_funct3 (r_funct3),
      .o_data   (w_aligned)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 3'd0;
         r_off       <= 2'd0;
         r_funct3    <= 3'd0;
         r_region    <= REG_NONE;
         r_rsp_data  <= '0;
         r_rsp_fault <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_off    <= req_addr[1:0];
                  r_funct3 <= req_funct3;
                  r_region <= w_region;
                  if (w_fault) begin
                     r_rsp_fault <= 1'b1;
                     r_rsp_data  <= '0;
                     r_state     <= ST_RESP;
                  end else begin
                     r_cnt   <= (w_region == REG_IO) ? c_IO_LAT : c_MEM_LAT;
                     r_state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               r_cnt <= r_cnt - 3'd1;
               // Data from the strobed source is valid in the last wait cycle
               if (r_cnt == 3'd1) begin
                  r_rsp_data  <= w_aligned;
                  r_rsp_fault <= 1'b0;
                  r_state     <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_ready) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_load_unit.sv
// ============================================================================
//  Module   : tb_mem_load_unit
//  Purpose  : Self-checking bench for mem_load_unit (MEM_LATENCY=1,
//             IO_LATENCY=3). Directed loads followed by random loads, all
//             checked cycle by cycle against a behavioural model of the
//             load rules (region map, latency, formatting, faults).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_load_unit;

   localparam int MEM_LAT = 1;
   localparam int IO_LAT  = 3;

   // Load encodings as defined by the ISA
   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [2:0]  req_funct3;
   logic [31:0] mem_addr;
   logic        dmem_en, bios_en, io_rd_en;
   logic [7:0]  io_addr;
   logic [31:0] dmem_rdata, bios_rdata, io_rdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_fault;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mem_load_unit #(
      .XLEN(32), .MEM_LATENCY(MEM_LAT), .IO_LATENCY(IO_LAT), .IO_ADDR_W(8)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_funct3(req_funct3),
      .mem_addr(mem_addr), .dmem_en(dmem_en), .bios_en(bios_en),
      .io_rd_en(io_rd_en), .io_addr(io_addr),
      .dmem_rdata(dmem_rdata), .bios_rdata(bios_rdata), .io_rdata(io_rdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_fault(rsp_fault)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---- reference model: 0 none, 1 dmem, 2 bios, 3 io ----
   function automatic int region_of(input logic [31:0] a);
      int n;
      n = int'(a[31:28]);
      if (n == 1 || n == 3) return 1;
      if (n == 4) return 2;
      if (n == 8) return 3;
      return 0;
   endfunction

   function automatic bit model_fault(input logic [31:0] a, input logic [2:0] f3);
      bit legal;
      legal = (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
      if (region_of(a) == 0 || !legal) return 1'b1;
`ifdef MEM_LOAD_MISALIGN_TRAP_EN
      if ((f3 == LH || f3 == LHU) && a[1:0] == 2'd3) return 1'b1;
      if (f3 == LW && a[1:0] != 2'd0) return 1'b1;
`endif
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_data(input logic [31:0] a, input logic [2:0] f3,
                                              input logic [31:0] w);
      int o;
      logic [31:0] b, h;
      o = int'(a[1:0]);
      b = (w >> (8 * o)) & 32'hFF;
      h = (w >> ((o == 3) ? 0 : 8 * o)) & 32'hFFFF;
      case (f3)
         LB:      return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
         LBU:     return b;
         LH:      return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
         LHU:     return h;
         default: return w;
      endcase
   endfunction

   task automatic scramble_rdata();
      dmem_rdata = $urandom;
      bios_rdata = $urandom;
      io_rdata   = $urandom;
   endtask

   // One complete transaction starting in an idle cycle T.
   task automatic do_load(input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] word, input int stall);
      int          reg_i, lat;
      bit          flt;
      logic [31:0] expd;
      reg_i = region_of(addr);
      flt   = model_fault(addr, f3);
      lat   = flt ? 0 : ((reg_i == 3) ? IO_LAT : MEM_LAT);
      expd  = flt ? 32'h0 : model_data(addr, f3, word);

      // accept cycle
      @(negedge clk);
      req_valid = 1'b1; req_addr = addr; req_funct3 = f3; rsp_ready = 1'b0;
      scramble_rdata();
      #1;
      check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      check("idle_req_ready", 32'(req_ready), 32'd1);
      check("accept_strobes", {29'd0, dmem_en, bios_en, io_rd_en},
            {29'd0, !flt && reg_i == 1, !flt && reg_i == 2, !flt && reg_i == 3});
      check("accept_mem_addr", mem_addr, addr);
      check("accept_io_addr", 32'(io_addr), {24'd0, addr[7:0]});
      @(posedge clk);

      // wait cycles: only the last one carries valid read data
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         req_valid = 1'($urandom % 2); req_addr = $urandom; req_funct3 = 3'($urandom);
         scramble_rdata();
         if (k == lat) begin
            if (reg_i == 1) dmem_rdata = word;
            else if (reg_i == 2) bios_rdata = word;
            else io_rdata = word;
         end
         #1;
         check("wait_rsp_valid", 32'(rsp_valid), 32'd0);
         check("wait_req_ready", 32'(req_ready), 32'd0);
         check("wait_strobes", {29'd0, dmem_en, bios_en, io_rd_en}, 32'd0);
         @(posedge clk);
      end

      // response cycles, stalled 'stall' times before acceptance
      for (int s = 0; s <= stall; s++) begin
         @(negedge clk);
         req_valid = 1'($urandom % 2); req_addr = $urandom; req_funct3 = 3'($urandom);
         rsp_ready = (s == stall);
         scramble_rdata();
         #1;
         check("resp_valid", 32'(rsp_valid), 32'd1);
         check("resp_data", rsp_data, expd);
         check("resp_fault", 32'(rsp_fault), 32'(flt));
         check("resp_req_ready", 32'(req_ready), 32'd0);
         check("resp_strobes", {29'd0, dmem_en, bios_en, io_rd_en}, 32'd0);
         @(posedge clk);
      end
   endtask

   initial begin
      logic [3:0]  nibs [8];
      logic [31:0] a;

      rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_funct3 = '0; rsp_ready = 1'b0;
      scramble_rdata();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_data", rsp_data, 32'd0);
      check("reset_rsp_fault", 32'(rsp_fault), 32'd0);
      check("reset_req_ready", 32'(req_ready), 32'd1);
      check("reset_strobes", {29'd0, dmem_en, bios_en, io_rd_en}, 32'd0);
      @(posedge clk);

      // directed loads
      do_load(32'h1000_0004, LW,  32'hDEAD_BEEF, 0);
      do_load(32'h4000_0003, LB,  32'h8012_3456, 0);
      do_load(32'h4000_0003, LBU, 32'h8012_3456, 0);
      do_load(32'h8000_0012, LHU, 32'hBEEF_0000, 0);
      do_load(32'h2000_0000, LW,  32'h1234_5678, 0);
      do_load(32'h3000_0008, LW,  32'hCAFE_F00D, 3);
      do_load(32'h1000_0003, LH,  32'h0000_F00D, 0);
      do_load(32'h1000_0001, 3'b011, 32'h5555_AAAA, 1);
      do_load(32'h8000_0002, LW,  32'h0BAD_CAFE, 0);

      // reset during WAIT of an IO load aborts it
      @(negedge clk);
      req_valid = 1'b1; req_addr = 32'h8000_0010; req_funct3 = LW;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
         check("abort_req_ready", 32'(req_ready), 32'd1);
         check("abort_rsp_data", rsp_data, 32'd0);
         check("abort_strobes", {29'd0, dmem_en, bios_en, io_rd_en}, 32'd0);
         @(negedge clk);
      end

      // random loads
      for (int n = 0; n < 40; n++) begin
         nibs[0] = 4'h1; nibs[1] = 4'h3; nibs[2] = 4'h4; nibs[3] = 4'h8;
         nibs[4] = 4'h2; nibs[5] = 4'h0; nibs[6] = 4'hF; nibs[7] = 4'($urandom);
         a = {nibs[$urandom_range(0, 7)], 28'($urandom)};
         do_load(a, 3'($urandom), $urandom, $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
